// File: rtl/getreg.sv
// getreg: RISC-V GPR index <-> ABI name translator for trace/debug printing.
// Forward path gives a combinational name plus a registered copy; the reverse
// path does a registered exact-match lookup of a 4-byte ASCII name.
// Names are right-justified ASCII with zero-filled high bytes.
module getreg #(
   parameter int IDX_W  = 5,   // only 5 is meaningful (32 GPRs)
   parameter int NAME_W = 32   // only 32 is meaningful (4 ASCII bytes)
) (
   input  logic              clk,
   input  logic              reset,      // async, active low
   input  logic              idx_valid,
   input  logic [IDX_W-1:0]  idx,
   output logic [NAME_W-1:0] name_comb,
   output logic              name_valid,
   output logic [NAME_W-1:0] name,
   input  logic              rev_valid,
   input  logic [NAME_W-1:0] rev_name,
   output logic              hit_valid,
   output logic              rev_hit,
   output logic [IDX_W-1:0]  rev_idx
);

   // "fp" is the frame-pointer alias for s0 (x8); only the reverse path knows it
   localparam logic [NAME_W-1:0] FP_NAME = 32'h0000_6670;
   localparam logic [IDX_W-1:0]  FP_IDX  = 5'd8;

   // ABI name table; every index has an entry
   function automatic logic [NAME_W-1:0] abi_name(input logic [IDX_W-1:0] i);
      logic [NAME_W-1:0] n;
      n = '0;
      case (i)
         5'd0:  n = 32'h7A65_726F; // zero
         5'd1:  n = 32'h0000_7261; // ra
         5'd2:  n = 32'h0000_7370; // sp
         5'd3:  n = 32'h0000_6770; // gp
         5'd4:  n = 32'h0000_7470; // tp
         5'd5:  n = 32'h0000_7430; // t0
         5'd6:  n = 32'h0000_7431; // t1
         5'd7:  n = 32'h0000_7432; // t2
         5'd8:  n = 32'h0000_7330; // s0
         5'd9:  n = 32'h0000_7331; // s1
         5'd10: n = 32'h0000_6130; // a0
         5'd11: n = 32'h0000_6131; // a1
         5'd12: n = 32'h0000_6132; // a2
         5'd13: n = 32'h0000_6133; // a3
         5'd14: n = 32'h0000_6134; // a4
         5'd15: n = 32'h0000_6135; // a5
         5'd16: n = 32'h0000_6136; // a6
         5'd17: n = 32'h0000_6137; // a7
         5'd18: n = 32'h0000_7332; // s2
         5'd19: n = 32'h0000_7333; // s3
         5'd20: n = 32'h0000_7334; // s4
         5'd21: n = 32'h0000_7335; // s5
         5'd22: n = 32'h0000_7336; // s6
         5'd23: n = 32'h0000_7337; // s7
         5'd24: n = 32'h0000_7338; // s8
         5'd25: n = 32'h0000_7339; // s9
         5'd26: n = 32'h0073_3130; // s10
         5'd27: n = 32'h0073_3131; // s11
         5'd28: n = 32'h0000_7433; // t3
         5'd29: n = 32'h0000_7434; // t4
         5'd30: n = 32'h0000_7435; // t5
         5'd31: n = 32'h0000_7436; // t6
      endcase
      return n;
   endfunction

   logic              name_valid_q, name_valid_d;
   logic [NAME_W-1:0] name_q, name_d;
   logic              hit_valid_q, hit_valid_d;
   logic              rev_hit_q, rev_hit_d;
   logic [IDX_W-1:0]  rev_idx_q, rev_idx_d;

   // Reverse match: table entries are unique, so at most one hits
   logic              match;
   logic [IDX_W-1:0]  match_idx;

   // Forward combinational lookup
   always_comb begin
      name_comb = abi_name(idx);
   end

   // Compare rev_name against all 32 entries plus the fp alias
   always_comb begin
      match     = 1'b0;
      match_idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (rev_name == abi_name(IDX_W'(i))) begin
            match     = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
      if (rev_name == FP_NAME) begin
         match     = 1'b1;
         match_idx = FP_IDX;
      end
   end

   // Next state: valids follow requests, data holds when not requested
   always_comb begin
      name_valid_d = idx_valid;
      name_d       = name_q;
      hit_valid_d  = rev_valid;
      rev_hit_d    = rev_hit_q;
      rev_idx_d    = rev_idx_q;
      if (idx_valid) name_d = name_comb;
      if (rev_valid) begin
         rev_hit_d = match;
         rev_idx_d = match ? match_idx : '0;
      end
   end

   // Output registers, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         name_valid_q <= 1'b0;
         name_q       <= '0;
         hit_valid_q  <= 1'b0;
         rev_hit_q    <= 1'b0;
         rev_idx_q    <= '0;
      end else begin
         name_valid_q <= name_valid_d;
         name_q       <= name_d;
         hit_valid_q  <= hit_valid_d;
         rev_hit_q    <= rev_hit_d;
         rev_idx_q    <= rev_idx_d;
      end
   end

   assign name_valid = name_valid_q;
   assign name       = name_q;
   assign hit_valid  = hit_valid_q;
   assign rev_hit    = rev_hit_q;
   assign rev_idx    = rev_idx_q;

endmodule

// File: tb/tb_getreg.sv
// Bench for getreg: reset, sweep, vector table, hold/reset corners, random
// traffic against a string-based model of the ABI name table.
module tb_getreg;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        idx_valid = 1'b0;
   logic [4:0]  idx = '0;
   logic [31:0] name_comb;
   logic        name_valid;
   logic [31:0] name;
   logic        rev_valid = 1'b0;
   logic [31:0] rev_name = '0;
   logic        hit_valid;
   logic        rev_hit;
   logic [4:0]  rev_idx;

   int vectors = 0;
   int miscompares = 0;

   getreg dut (
      .clk(clk), .reset(reset),
      .idx_valid(idx_valid), .idx(idx), .name_comb(name_comb),
      .name_valid(name_valid), .name(name),
      .rev_valid(rev_valid), .rev_name(rev_name),
      .hit_valid(hit_valid), .rev_hit(rev_hit), .rev_idx(rev_idx)
   );

   always #5 clk = ~clk;

   // Model: ABI names as text, packed right-justified
   string abi [32] = '{"zero","ra","sp","gp","tp","t0","t1","t2","s0","s1",
                       "a0","a1","a2","a3","a4","a5","a6","a7",
                       "s2","s3","s4","s5","s6","s7","s8","s9","s10","s11",
                       "t3","t4","t5","t6"};

   function automatic logic [31:0] pack(input string s);
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < s.len(); k++) v = {v[23:0], s[k]};
      return v;
   endfunction

   function automatic logic [31:0] m_name(input int i);
      return pack(abi[i]);
   endfunction

   // Returns index on hit, -1 otherwise
   function automatic int m_lookup(input logic [31:0] n);
      if (n == pack("fp")) return 8;
      for (int i = 0; i < 32; i++) if (pack(abi[i]) == n) return i;
      return -1;
   endfunction

   task automatic chk(input string what, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", what, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [4:0]  i;
      logic [31:0] rn;
      logic [31:0] e_name;
      logic        e_hit;
      logic [4:0]  e_ridx;
   } vec_t;

   vec_t vt [5];

   // model of registered state for random phase
   logic        e_nv, e_hv, e_hit;
   logic [31:0] e_name;
   logic [4:0]  e_ridx;

   initial begin
      vt[0] = '{5'd2,  32'h0000_7433, 32'h0000_7370, 1'b1, 5'd28}; // sp / t3
      vt[1] = '{5'd10, 32'h0000_6670, 32'h0000_6130, 1'b1, 5'd8};  // a0 / fp
      vt[2] = '{5'd27, 32'h0000_7835, 32'h0073_3131, 1'b0, 5'd0};  // s11 / x5
      vt[3] = '{5'd31, 32'h0000_4130, 32'h0000_7436, 1'b0, 5'd0};  // t6 / "A0"
      vt[4] = '{5'd1,  32'h0000_6770, 32'h0000_7261, 1'b1, 5'd3};  // ra / gp

      // Reset held with a request pending: nothing registers
      idx_valid = 1'b1; idx = 5'd0; rev_valid = 1'b1; rev_name = 32'h0000_7261;
      step(); step();
      chk("rst name_valid", 32'(name_valid), 32'd0);
      chk("rst name",       name,            32'd0);
      chk("rst hit_valid",  32'(hit_valid),  32'd0);
      chk("rst rev_hit",    32'(rev_hit),    32'd0);
      chk("rst rev_idx",    32'(rev_idx),    32'd0);

      // Release; first request idx=0
      reset = 1'b1; rev_valid = 1'b0;
      step();
      chk("first name_valid", 32'(name_valid), 32'd1);
      chk("first name",       name,            32'h7A65_726F);
      chk("first hit_valid",  32'(hit_valid),  32'd0);

      // Sweep: comb name now, registered name one cycle later
      for (int i = 0; i < 32; i++) begin
         idx = 5'(i); idx_valid = 1'b1;
         #1;
         chk($sformatf("comb idx%0d", i), name_comb, m_name(i));
         step();
         chk($sformatf("reg idx%0d", i), name, m_name(i));
      end

      // Vector table: both paths each cycle
      for (int v = 0; v < 5; v++) begin
         idx_valid = 1'b1; idx = vt[v].i; rev_valid = 1'b1; rev_name = vt[v].rn;
         step();
         chk($sformatf("vec%0d name", v),    name,             vt[v].e_name);
         chk($sformatf("vec%0d nvalid", v),  32'(name_valid),  32'd1);
         chk($sformatf("vec%0d hvalid", v),  32'(hit_valid),   32'd1);
         chk($sformatf("vec%0d hit", v),     32'(rev_hit),     32'(vt[v].e_hit));
         chk($sformatf("vec%0d ridx", v),    32'(rev_idx),     32'(vt[v].e_ridx));
      end

      // Hit "t3", then garbage high byte misses, then hold for 3 idle cycles
      idx_valid = 1'b0; rev_valid = 1'b1; rev_name = 32'h0000_7433;
      step();
      chk("t3 ridx", 32'(rev_idx), 32'd28);
      rev_name = 32'h0173_3130;
      step();
      chk("garbage hit",  32'(rev_hit), 32'd0);
      chk("garbage ridx", 32'(rev_idx), 32'd0);
      chk("idle name hold", name, 32'h0000_7261);
      rev_valid = 1'b0; rev_name = 32'h0000_6770;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("idle hvalid", 32'(hit_valid), 32'd0);
         chk("idle hit",    32'(rev_hit),   32'd0);
         chk("idle ridx",   32'(rev_idx),   32'd0);
      end
      // Hold of a non-zero result while idle
      rev_valid = 1'b1; rev_name = 32'h0000_6133; // a3
      step();
      rev_valid = 1'b0; rev_name = 32'h0;
      step(); step();
      chk("hold hit",  32'(rev_hit), 32'd1);
      chk("hold ridx", 32'(rev_idx), 32'd13);

      // Round trip over the whole table
      for (int i = 0; i < 32; i++) begin
         rev_valid = 1'b1; rev_name = m_name(i);
         step();
         chk($sformatf("rt hit%0d", i),  32'(rev_hit), 32'd1);
         chk($sformatf("rt idx%0d", i),  32'(rev_idx), 32'(i));
      end

      // Random traffic vs model
      e_nv = name_valid; e_name = name; e_hv = hit_valid; e_hit = rev_hit; e_ridx = rev_idx;
      for (int c = 0; c < 400; c++) begin
         int li;
         idx_valid = 1'($urandom_range(0, 1));
         idx       = 5'($urandom_range(0, 31));
         rev_valid = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: rev_name = m_name($urandom_range(0, 31));
            1: rev_name = pack("fp");
            2: rev_name = m_name($urandom_range(0, 31)) ^ (32'h1 << $urandom_range(0, 31));
            default: rev_name = $urandom;
         endcase
         #1;
         chk("rnd comb", name_comb, m_name(int'(idx)));
         e_nv = idx_valid;
         if (idx_valid) e_name = m_name(int'(idx));
         e_hv = rev_valid;
         if (rev_valid) begin
            li = m_lookup(rev_name);
            e_hit  = (li >= 0);
            e_ridx = (li >= 0) ? 5'(li) : 5'd0;
         end
         step();
         chk("rnd nvalid", 32'(name_valid), 32'(e_nv));
         chk("rnd name",   name,            e_name);
         chk("rnd hvalid", 32'(hit_valid),  32'(e_hv));
         chk("rnd hit",    32'(rev_hit),    32'(e_hit));
         chk("rnd ridx",   32'(rev_idx),    32'(e_ridx));
      end

      // Mid-cycle async reset clears immediately
      idx_valid = 1'b1; idx = 5'd5; rev_valid = 1'b1; rev_name = 32'h0000_7470;
      step();
      chk("pre-rst ridx", 32'(rev_idx), 32'd4);
      #2 reset = 1'b0;
      #1;
      chk("async name_valid", 32'(name_valid), 32'd0);
      chk("async name",       name,            32'd0);
      chk("async hit_valid",  32'(hit_valid),  32'd0);
      chk("async rev_hit",    32'(rev_hit),    32'd0);
      chk("async rev_idx",    32'(rev_idx),    32'd0);
      step();
      chk("rst drop nvalid", 32'(name_valid), 32'd0);
      reset = 1'b1;
      step();
      chk("post-rst name", name, 32'h0000_7430);
      chk("post-rst ridx", 32'(rev_idx), 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
